vga_mode_ctrl: RTL
==================

// Module: vga_mode_ctrl
// PURPOSE
// - Run-time video-mode controller for the VGA pipeline (frame_gen -> vga).
// - Accepts a mode index over a valid/ready handshake and waits for a frame boundary (sof).
// - Holds the pixel datapath in reset, loads the timing set from vga_pkg::vga_configs, then releases the datapath.
// - Guarantees timing outputs change only while the datapath is held in reset.
// PARAMETERS
// - N_MODES       $size(vga_pkg::vga_configs)  number of selectable modes
// - MODE_W        $clog2(N_MODES)              width of mode index
// - DEFAULT_MODE  3                            mode loaded out of reset
// - HOLD_CYCLES   16                           datapath reset hold length, >=1
// - SOF_TIMEOUT   2**21                        max WAIT_SOF cycles before forced switch, >=1
// PORTS
// - aclk           in   1       system clock
// - aresetn        in   1       synchronous reset, active low
// - cfg_tvalid     in   1       mode request valid
// - cfg_tready     out  1       mode request ready
// - cfg_tdata      in   MODE_W  requested mode index
// - sof            in   1       start-of-frame pulse from vga
// - dp_aresetn     out  1       sync active-low reset to frame_gen/vga
// - h_res, h_front_porch, h_sync_pulse, h_back_porch   out  16 each  horizontal timing
// - v_res, v_front_porch, v_sync_pulse, v_back_porch   out  16 each  vertical timing
// - cur_mode       out  MODE_W  mode currently applied
// - busy           out  1       high whenever state != IDLE
// - cfg_done       out  1       1-cycle pulse: request completed
// - cfg_err        out  1       1-cycle pulse: request index >= N_MODES
// - sof_timeout    out  1       1-cycle pulse: switch forced by timeout
// BEHAVIOUR
// - Reset (aresetn=0 on a clock edge, any state): state<=HOLD; cnt<=0; pending<=DEFAULT_MODE.
//   - cur_mode and timing regs <= vga_configs[DEFAULT_MODE].
//   - cfg_done/cfg_err/sof_timeout <= 0; any pending request is discarded.
// - Moore outputs, decoded from the state register:
//   - dp_aresetn = 0 iff state in {HOLD, LOAD}.
//   - cfg_tready = 1 iff state == IDLE.
//   - busy = 1 iff state != IDLE.
// - States:
//   - IDLE: on cfg_tvalid & cfg_tready:
//     - cfg_tdata >= N_MODES: cfg_err=1 next cycle, stay IDLE.
//     - cfg_tdata == cur_mode: cfg_done=1 next cycle, stay IDLE, no datapath reset.
//     - else: pending<=cfg_tdata, cnt<=0, ->WAIT_SOF.
//   - WAIT_SOF: cnt++ each cycle.
//     - sof=1 -> HOLD, cnt<=0.
//     - else if cnt==SOF_TIMEOUT-1 -> HOLD, cnt<=0, sof_timeout=1 next cycle.
//     - sof on the timeout cycle: sof wins, no sof_timeout.
//   - HOLD: cnt++; when cnt==HOLD_CYCLES-1 -> LOAD. dp_aresetn low for HOLD_CYCLES cycles.
//   - LOAD (1 cycle): timing regs <= vga_configs[pending]; cur_mode <= pending; ->SETTLE.
//   - SETTLE (1 cycle): dp_aresetn high; cfg_done=1 next cycle, unless this cycle is the post-reset default load; ->IDLE.
// - Latency: sof sampled in cycle k -> dp_aresetn low k+1..k+HOLD_CYCLES+1 -> high at k+HOLD_CYCLES+2.
//   - cfg_done asserted at k+HOLD_CYCLES+3.
// - Widths and timeouts:
//   - Timing regs are 16 bit, zero-extended from the package int fields.
//   - cnt width = $clog2(max(SOF_TIMEOUT,HOLD_CYCLES)+1); cnt never wraps.
// - sof outside WAIT_SOF is ignored. cfg_tdata is sampled only on handshake.
// - Pulse outputs are mutually exclusive per cycle.
// STRUCTURE
// - vga_pkg additions:
//   - vga_mode_ctrl_state_t enum {IDLE, WAIT_SOF, HOLD, LOAD, SETTLE}.
//   - vga_timing_t packed struct of the eight 16-bit fields.
//   - function to_timing(int idx) returning vga_timing_t from vga_configs.
// - No sub-module: lookup, FSM and counter are all single-file.
// - vga_top instantiates vga_mode_ctrl between core_wrapper and frame_gen/vga.
//   - frame_gen and vga take dp_aresetn in place of aresetn.
// TESTING
// - Reset then release: dp_aresetn=0 for 18 cycles, then 1; h_res==vga_configs[3].H_RES; cfg_tready=1; cfg_done never pulses.
// - Request mode 1, sof 100 cycles later: tready drops next cycle; dp_aresetn low cycles 101..117.
//   - Timing==vga_configs[1] from cycle 118; cfg_done at cycle 119; cur_mode=1.
// - cfg_tdata=N_MODES: cfg_err single pulse; timing, cur_mode, dp_aresetn unchanged; tready stays 1.
// - Request cur_mode (3): cfg_done next cycle; dp_aresetn never drops; busy never rises.
// - SOF_TIMEOUT=64, no sof: sof_timeout pulse at 64 cycles after accept; switch completes normally.
//   - Repeat with sof on cycle 63: no sof_timeout.
// - aresetn low mid-HOLD of a mode-1 switch: after release, default mode reloaded.
//   - dp_aresetn low for 18 cycles; no cfg_done; cur_mode=3.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: video-mode table and shared types for the VGA pipeline.
// Contents: vga_configs (per-mode timing in pixels/lines), mode-controller state
//           enum, 16-bit timing bundle vga_timing_t and the to_timing() lookup.
package vga_pkg;

    typedef struct packed {
        int H_RES;
        int H_FRONT_PORCH;
        int H_SYNC_PULSE;
        int H_BACK_PORCH;
        int V_RES;
        int V_FRONT_PORCH;
        int V_SYNC_PULSE;
        int V_BACK_PORCH;
    } vga_config_t;

    localparam int N_VGA_CONFIGS = 5;
    localparam int VGA_IDX_W     = $clog2(N_VGA_CONFIGS);

    // 0: 640x480, 1: 800x600, 2: 1024x768, 3: 1280x720, 4: 1920x1080 (all 60 Hz)
    localparam vga_config_t vga_configs [N_VGA_CONFIGS] = '{
        '{ 640,  16,  96,  48,  480, 10, 2, 33},
        '{ 800,  40, 128,  88,  600,  1, 4, 23},
        '{1024,  24, 136, 160,  768,  3, 6, 29},
        '{1280, 110,  40, 220,  720,  5, 5, 20},
        '{1920,  88,  44, 148, 1080,  4, 5, 36}
    };

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SOF,
        HOLD,
        LOAD,
        SETTLE
    } vga_mode_ctrl_state_t;

    typedef struct packed {
        logic [15:0] h_res;
        logic [15:0] h_front_porch;
        logic [15:0] h_sync_pulse;
        logic [15:0] h_back_porch;
        logic [15:0] v_res;
        logic [15:0] v_front_porch;
        logic [15:0] v_sync_pulse;
        logic [15:0] v_back_porch;
    } vga_timing_t;

    // Out-of-range indices return an all-zero timing set.
    function automatic vga_timing_t to_timing(input int idx);
        vga_timing_t t;
        vga_config_t c;
        t = '0;
        if (idx >= 0 && idx < N_VGA_CONFIGS) begin
            c = vga_configs[VGA_IDX_W'(idx)];
            t.h_res         = c.H_RES[15:0];
            t.h_front_porch = c.H_FRONT_PORCH[15:0];
            t.h_sync_pulse  = c.H_SYNC_PULSE[15:0];
            t.h_back_porch  = c.H_BACK_PORCH[15:0];
            t.v_res         = c.V_RES[15:0];
            t.v_front_porch = c.V_FRONT_PORCH[15:0];
            t.v_sync_pulse  = c.V_SYNC_PULSE[15:0];
            t.v_back_porch  = c.V_BACK_PORCH[15:0];
        end
        return t;
    endfunction

endpackage

// File: rtl/vga_mode_ctrl.sv
// vga_mode_ctrl: run-time video-mode switch; waits for sof, holds datapath in reset, loads timing.
// Latency: sof in cycle k -> dp_aresetn low k+1..k+HOLD_CYCLES+1, cfg_done at k+HOLD_CYCLES+3.
// Backpressure: cfg_tready high only in IDLE; requests are accepted one at a time.
// Ports: aclk/aresetn (sync, active low); cfg_tvalid/cfg_tready/cfg_tdata mode request;
//        sof frame boundary; dp_aresetn datapath reset; h_*/v_* 16-bit timing; cur_mode;
//        busy; cfg_done/cfg_err/sof_timeout single-cycle status pulses.
module vga_mode_ctrl
    import vga_pkg::*;
#(
    parameter int N_MODES      = $size(vga_configs),
    parameter int MODE_W       = $clog2(N_MODES),
    parameter int DEFAULT_MODE = 3,
    parameter int HOLD_CYCLES  = 16,
    parameter int SOF_TIMEOUT  = 2**21
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              cfg_tvalid,
    output logic              cfg_tready,
    input  logic [MODE_W-1:0] cfg_tdata,
    input  logic              sof,
    output logic              dp_aresetn,
    output logic [15:0]       h_res,
    output logic [15:0]       h_front_porch,
    output logic [15:0]       h_sync_pulse,
    output logic [15:0]       h_back_porch,
    output logic [15:0]       v_res,
    output logic [15:0]       v_front_porch,
    output logic [15:0]       v_sync_pulse,
    output logic [15:0]       v_back_porch,
    output logic [MODE_W-1:0] cur_mode,
    output logic              busy,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic              sof_timeout
);

    localparam int CNT_MAX = (SOF_TIMEOUT > HOLD_CYCLES) ? SOF_TIMEOUT : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  SOF_LAST  = CNT_W'(SOF_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [MODE_W-1:0] DEF_IDX   = MODE_W'(DEFAULT_MODE);

    vga_mode_ctrl_state_t state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [MODE_W-1:0]    pending_q, pending_d;
    logic [MODE_W-1:0]    cur_mode_q, cur_mode_d;
    vga_timing_t          timing_q, timing_d;
    // Marks a sequence started by reset: its SETTLE must not report cfg_done.
    logic                 boot_q, boot_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 to_q, to_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        cur_mode_d = cur_mode_q;
        timing_d   = timing_q;
        boot_d     = boot_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        to_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cfg_tvalid) begin
                    if (int'(cfg_tdata) >= N_MODES) begin
                        err_d = 1'b1;
                    end else if (cfg_tdata == cur_mode_q) begin
                        // Already applied: acknowledge without disturbing the datapath.
                        done_d = 1'b1;
                    end else begin
                        pending_d = cfg_tdata;
                        cnt_d     = '0;
                        state_d   = WAIT_SOF;
                    end
                end
            end
            WAIT_SOF: begin
                cnt_d = cnt_q + CNT_ONE;
                // A real frame boundary takes priority over the timeout on the same cycle.
                if (sof) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == SOF_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    to_d    = 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            LOAD: begin
                // Timing changes here, while dp_aresetn is still low.
                timing_d   = to_timing(int'(pending_q));
                cur_mode_d = pending_q;
                state_d    = SETTLE;
            end
            SETTLE: begin
                done_d  = !boot_q;
                boot_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= HOLD;
            cnt_q      <= '0;
            pending_q  <= DEF_IDX;
            cur_mode_q <= DEF_IDX;
            timing_q   <= to_timing(DEFAULT_MODE);
            boot_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            cur_mode_q <= cur_mode_d;
            timing_q   <= timing_d;
            boot_q     <= boot_d;
            done_q     <= done_d;
            err_q      <= err_d;
            to_q       <= to_d;
        end
    end

    assign dp_aresetn = (state_q != HOLD) && (state_q != LOAD);
    assign cfg_tready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);

    assign cfg_done    = done_q;
    assign cfg_err     = err_q;
    assign sof_timeout = to_q;
    assign cur_mode    = cur_mode_q;

    assign h_res         = timing_q.h_res;
    assign h_front_porch = timing_q.h_front_porch;
    assign h_sync_pulse  = timing_q.h_sync_pulse;
    assign h_back_porch  = timing_q.h_back_porch;
    assign v_res         = timing_q.v_res;
    assign v_front_porch = timing_q.v_front_porch;
    assign v_sync_pulse  = timing_q.v_sync_pulse;
    assign v_back_porch  = timing_q.v_back_porch;

endmodule
